mem_dump_reader: RTL

Read-side initiator for the MIPS data memory. On a start pulse it reads a block of consecutive data-memory words through the memory's registered read port, splits each word into bytes, and streams them MSB-first over a valid/ready byte interface to the debug UART transmitter. It sits between the data memory's read port and the debug unit's TX path. It owns the memory port only while `busy` is high.

---
 rtl/mem_dump_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_dump_reader.sv
// mem_dump_reader: reads a block of data-memory words through a two-edge
// registered read port and streams each word MSB-first as bytes to the
// debug transmitter.
//
// Byte handshake: tx_valid is raised only in TX and, once raised, tx_valid
// and tx_data stay constant until a rising edge where tx_valid && tx_ready;
// that edge transfers exactly one byte. The receiver may hold tx_ready low
// for any number of cycles.
module mem_dump_reader #(
  parameter int len_addr  = 32,
  parameter int len_data  = 32,
  parameter int ram_depth = 2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [len_addr-1:0] start_addr,
  input  logic [len_addr-1:0] n_words,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [len_addr-1:0] mem_addr,
  input  logic [len_data-1:0] mem_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [2:0]          o_dbg_state
);

  localparam int BPW  = len_data / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [len_addr-1:0] DEPTH    = len_addr'(ram_depth);
  localparam logic [len_addr-1:0] ONE      = len_addr'(1);
  localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_TX   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [len_addr-1:0] r_cur;
  logic [len_addr-1:0] r_remaining;
  logic [len_data-1:0] r_word;
  logic [IDXW-1:0]     r_idx;
  logic [len_addr-1:0] w_cnt;
  logic [len_addr-1:0] w_start_cur;
  logic [len_addr-1:0] w_next_cur;
  logic [len_data-1:0] w_shifted;
  logic                w_xfer;
  logic                w_last_byte;

  // Word count is clamped to the memory size; addresses wrap at the top.
  assign w_cnt       = (n_words > DEPTH) ? DEPTH : n_words;
  assign w_start_cur = start_addr % DEPTH;
  assign w_next_cur  = (r_cur == DEPTH - ONE) ? '0 : r_cur + ONE;

  // Current byte is always the top byte of the word shifted by idx bytes.
  assign w_shifted   = r_word << {r_idx, 3'b000};
  assign w_xfer      = (r_state == S_TX) && tx_ready;
  assign w_last_byte = w_xfer && (r_idx == LAST_IDX);

  assign mem_wr      = 1'b0;
  assign mem_addr    = r_cur;
  assign o_dbg_state = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next   = r_state;
    mem_rd   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (w_cnt == '0) ? S_DONE : S_RD0;
      end
      S_RD0: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        w_next = S_RD1;
      end
      S_RD1: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        w_next = S_RD2;
      end
      S_RD2: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        w_next = S_TX;
      end
      S_TX: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = w_shifted[len_data-1 -: 8];
        if (w_last_byte) w_next = (r_remaining == ONE) ? S_DONE : S_RD0;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address, word-count, captured word and byte index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur       <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (w_cnt != '0)) begin
            r_cur       <= w_start_cur;
            r_remaining <= w_cnt;
          end
        end
        S_RD2: begin
          r_word <= mem_data;
          r_idx  <= '0;
        end
        S_TX: begin
          if (w_xfer) r_idx <= r_idx + 1'b1;
          if (w_last_byte) begin
            r_remaining <= r_remaining - ONE;
            if (r_remaining != ONE) r_cur <= w_next_cur;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
